// File: rtl/coproc_cmd_sched.sv
// -----------------------------------------------------------------------------
// coproc_cmd_sched
//   Command front-end for the image coprocessor. Host commands
//   {func, gray, img_idx} are buffered in a CMD_DEPTH-entry FIFO. Each command
//   is launched to the engine (eng_start) and then walked row by row over an
//   IMG_H-row image, using a row_req/row_ack handshake.
//
//   Optional feature macro: COPROC_ABORT_EN
//     When defined, adds input 'abort'. It flushes the queue, drops the
//     in-flight command without a done pulse, and discards a same-cycle start.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start/gray/img_idx/func   host command strobe and fields
//   rdy                 queue not full (registered)
//   busy                queue non-empty or a command in flight
//   done                one-cycle pulse per completed command
//   err_ovf             sticky: start while rdy low
//   err_idx             one-cycle pulse: start rejected, img_idx >= NUM_IMG
//   eng_start           one-cycle launch pulse to the engine
//   eng_func/eng_gray   fields of the most recently launched command
//   row_req/row_addr    row request, address = img_idx*IMG_H + row
//   row_ack             engine accepts the current row
//   abort               (COPROC_ABORT_EN only) flush and return to idle
// -----------------------------------------------------------------------------
module coproc_cmd_sched #(
    parameter int IMG_H     = 256,
    parameter int NUM_IMG   = 2,
    parameter int FUNC_W    = 3,
    parameter int CMD_DEPTH = 4,
    parameter int IDX_W     = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
    parameter int ADDR_W    = (NUM_IMG * IMG_H > 1) ? $clog2(NUM_IMG * IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              gray,
    input  logic [IDX_W-1:0]  img_idx,
    input  logic [FUNC_W-1:0] func,
    output logic              rdy,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_idx,
    output logic              eng_start,
    output logic [FUNC_W-1:0] eng_func,
    output logic              eng_gray,
    output logic              row_req,
    output logic [ADDR_W-1:0] row_addr,
    input  logic              row_ack
`ifdef COPROC_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, ROW, FINISH} state_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic              gray;
        logic [IDX_W-1:0]  idx;
    } cmd_t;

    logic abort_w;
`ifdef COPROC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    state_t            state_q, state_d;
    cmd_t              mem_q [CMD_DEPTH];
    cmd_t              mem_d [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [FUNC_W-1:0] eng_func_q, eng_func_d;
    logic              eng_gray_q, eng_gray_d;
    logic              eng_start_q, eng_start_d;
    logic              row_req_q, row_req_d;
    logic              done_q, done_d;
    logic              rdy_q, rdy_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_idx_q, err_idx_d;

    logic idx_ok, push, pop;
    cmd_t head;

    always_comb begin
        // With a power-of-two NUM_IMG this is constant-true; kept for other sizes.
        idx_ok = (32'(img_idx) < 32'(NUM_IMG));
        // rdy_q already reflects fullness after last cycle's push/pop, so a
        // full queue never accepts a push even when it pops this cycle.
        push   = start && rdy_q && idx_ok && !abort_w;
        pop    = (state_q == IDLE) && (cnt_q != '0) && !abort_w;
        head   = mem_q[rd_ptr_q];

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        row_d       = row_q;
        idx_d       = idx_q;
        row_addr_d  = row_addr_q;
        eng_func_d  = eng_func_q;
        eng_gray_d  = eng_gray_q;
        row_req_d   = row_req_q;
        eng_start_d = 1'b0;
        done_d      = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = '{func: func, gray: gray, idx: img_idx};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Bad index wins over overflow: such a start never sets err_ovf.
        err_idx_d = start && !idx_ok;
        err_ovf_d = err_ovf_q || (start && idx_ok && !rdy_q);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    eng_func_d  = head.func;
                    eng_gray_d  = head.gray;
                    idx_d       = head.idx;
                    eng_start_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                row_d      = '0;
                row_addr_d = ADDR_W'(idx_q) * ADDR_W'(IMG_H);
                row_req_d  = 1'b1;
                state_d    = ROW;
            end
            ROW: begin
                if (row_ack) begin
                    if (row_q == ROW_W'(IMG_H - 1)) begin
                        row_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        row_d      = row_q + ROW_W'(1);
                        row_addr_d = row_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;  // FINISH
        endcase

        if (abort_w) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            state_d     = IDLE;
            row_d       = '0;
            row_req_d   = 1'b0;
            eng_start_d = 1'b0;
            done_d      = 1'b0;
        end

        rdy_d = (cnt_d != CNT_W'(CMD_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            row_addr_q  <= '0;
            eng_func_q  <= '0;
            eng_gray_q  <= 1'b0;
            eng_start_q <= 1'b0;
            row_req_q   <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b1;
            err_ovf_q   <= 1'b0;
            err_idx_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            idx_q       <= idx_d;
            row_addr_q  <= row_addr_d;
            eng_func_q  <= eng_func_d;
            eng_gray_q  <= eng_gray_d;
            eng_start_q <= eng_start_d;
            row_req_q   <= row_req_d;
            done_q      <= done_d;
            rdy_q       <= rdy_d;
            err_ovf_q   <= err_ovf_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign rdy       = rdy_q;
    assign busy      = (cnt_q != '0) || (state_q != IDLE);
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_idx   = err_idx_q;
    assign eng_start = eng_start_q;
    assign eng_func  = eng_func_q;
    assign eng_gray  = eng_gray_q;
    assign row_req   = row_req_q;
    assign row_addr  = row_addr_q;

endmodule

// File: tb/tb_coproc_cmd_sched.sv
// Self-checking bench for coproc_cmd_sched. NUM_IMG=3 so that an out-of-range
// img_idx (3) is representable. A negedge monitor tracks the commands the
// host posted and predicts every launch and row address from them.
module tb_coproc_cmd_sched;
    localparam int IMG_H   = 256;
    localparam int NUM_IMG = 3;
    localparam int IDX_W   = 2;
    localparam int ADDR_W  = 10;

    typedef struct {
        logic [2:0] f;
        logic       g;
        int         idx;
    } cmd_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, gray = 1'b0;
    logic row_ack = 1'b0, abort = 1'b0;
    logic [IDX_W-1:0] img_idx = '0;
    logic [2:0] func = '0;
    logic rdy, busy, done, err_ovf, err_idx, eng_start, eng_gray, row_req;
    logic [2:0] eng_func;
    logic [ADDR_W-1:0] row_addr;

    coproc_cmd_sched #(.IMG_H(IMG_H), .NUM_IMG(NUM_IMG), .FUNC_W(3), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gray(gray), .img_idx(img_idx),
        .func(func), .rdy(rdy), .busy(busy), .done(done), .err_ovf(err_ovf),
        .err_idx(err_idx), .eng_start(eng_start), .eng_func(eng_func),
        .eng_gray(eng_gray), .row_req(row_req), .row_addr(row_addr),
        .row_ack(row_ack)
`ifdef COPROC_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    cmd_t pend[$];          // commands the host posted that have not launched
    cmd_t m_c;
    bit   m_active = 1'b0;
    int   m_idx = 0, m_rows = 0, m_dones = 0, m_exp = 0;

    // Reference model: commands launch in posting order, each walks rows
    // idx*IMG_H .. idx*IMG_H+IMG_H-1 once, advancing only on an ack.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_rows   = 0;
        end else begin
            if (eng_start === 1'b1) begin
                n_cmp++;
                if (pend.size() == 0) begin
                    n_bad++;
                    $display("FAIL launch: eng_start with no pending command");
                end else begin
                    m_c = pend.pop_front();
                    if ({eng_func, eng_gray} !== {m_c.f, m_c.g}) begin
                        n_bad++;
                        $display("FAIL launch_fields: got func=%0d gray=%0d expected func=%0d gray=%0d",
                                 eng_func, eng_gray, m_c.f, m_c.g);
                    end
                    m_idx    = m_c.idx;
                    m_active = 1'b1;
                    m_rows   = 0;
                end
            end
            if (row_req === 1'b1) begin
                m_exp = m_idx * IMG_H + m_rows;
                n_cmp++;
                if (!m_active || row_addr !== ADDR_W'(m_exp)) begin
                    n_bad++;
                    $display("FAIL row_addr: got %0d expected %0d (active=%0d)", row_addr, m_exp, m_active);
                end
                if (row_ack === 1'b1) m_rows++;
            end
            if (done === 1'b1) begin
                n_cmp++;
                if (!m_active || m_rows != IMG_H) begin
                    n_bad++;
                    $display("FAIL done_rows: got %0d rows (active=%0d) expected %0d", m_rows, m_active, IMG_H);
                end
                m_active = 1'b0;
                m_dones++;
            end
            if (abort === 1'b1) begin
                m_active = 1'b0;
                pend.delete();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic [2:0] f, input logic g, input int i);
        start = 1'b1; func = f; gray = g; img_idx = IDX_W'(i);
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst_n = 1'b0;
        cyc(); cyc();
        obs = {rdy, busy, done, err_ovf, err_idx, eng_start, eng_func, eng_gray, row_req, row_addr};
        n_cmp++;
        if (obs !== 21'h100000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 21'h100000);
        end
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if ({rdy, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL post_reset_idle: got rdy,busy=%b expected 10", {rdy, busy});
        end
    endtask

    task automatic test_single();
        int t_es = -1, t_dn = -1, n_dn = 0;
        cmd_t c;
        c.f = 3'b010; c.g = 1'b1; c.idx = 1;
        row_ack = 1'b1;
        pend.push_back(c);
        post(3'b010, 1'b1, 1);
        for (int m = 0; m < 300; m++) begin
            if (m == 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL single_busy: got %b expected 1", busy);
                end
            end
            if (eng_start === 1'b1 && t_es < 0) t_es = m;
            if (done === 1'b1) begin
                n_dn++;
                if (t_dn < 0) t_dn = m;
            end
            cyc();
        end
        n_cmp++;
        if (t_es != 1) begin n_bad++; $display("FAIL single_launch_latency: got %0d expected 1", t_es); end
        n_cmp++;
        if (n_dn != 1) begin n_bad++; $display("FAIL single_done_count: got %0d expected 1", n_dn); end
        n_cmp++;
        if (t_dn != 258) begin n_bad++; $display("FAIL single_done_latency: got %0d expected 258", t_dn); end
        n_cmp++;
        if ({busy, eng_func, eng_gray} !== {1'b0, 3'b010, 1'b1}) begin
            n_bad++;
            $display("FAIL single_end_state: got busy=%b func=%0d gray=%b expected busy=0 func=2 gray=1",
                     busy, eng_func, eng_gray);
        end
    endtask

    task automatic test_err_idx();
        post(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3);
        n_cmp++;
        if ({err_idx, err_ovf, busy, rdy} !== 4'b1001) begin
            n_bad++;
            $display("FAIL err_idx_pulse: got err_idx,err_ovf,busy,rdy=%b expected 1001", {err_idx, err_ovf, busy, rdy});
        end
        cyc();
        n_cmp++;
        if ({err_idx, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_idx_clear: got err_idx,busy=%b expected 00", {err_idx, busy});
        end
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        int d0 = m_dones;
        row_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c.f = 3'($urandom_range(0, 7)); c.g = 1'($urandom_range(0, 1)); c.idx = $urandom_range(0, 2);
            pend.push_back(c);
            post(c.f, c.g, c.idx);
            n_cmp++;
            if (rdy !== (k < 4)) begin
                n_bad++;
                $display("FAIL b2b_rdy: after start %0d got %b expected %b", k, rdy, (k < 4));
            end
        end
        post(3'd7, 1'b0, 0);  // queue full: must be dropped
        n_cmp++;
        if ({err_ovf, err_idx, rdy, busy} !== 4'b1001) begin
            n_bad++;
            $display("FAIL b2b_overflow: got err_ovf,err_idx,rdy,busy=%b expected 1001", {err_ovf, err_idx, rdy, busy});
        end
        row_ack = 1'b1;
        for (int c2 = 0; c2 < 1500 && (m_dones - d0) < 5; c2++) cyc();
        for (int c2 = 0; c2 < 10; c2++) cyc();
        n_cmp++;
        if (m_dones - d0 != 5 || pend.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d dones, %0d pending expected 5 dones, 0 pending",
                     m_dones - d0, pend.size());
        end
        n_cmp++;
        if ({busy, rdy, err_ovf} !== 3'b011) begin
            n_bad++;
            $display("FAIL b2b_end_state: got busy,rdy,err_ovf=%b expected 011", {busy, rdy, err_ovf});
        end
    endtask

    task automatic test_random_gaps();
        cmd_t c;
        int d0 = m_dones;
        for (int k = 0; k < 3; k++) begin
            c.f = 3'($urandom_range(0, 7)); c.g = 1'($urandom_range(0, 1)); c.idx = $urandom_range(0, 2);
            pend.push_back(c);
            post(c.f, c.g, c.idx);
        end
        for (int c2 = 0; c2 < 5000 && (m_dones - d0) < 3; c2++) begin
            row_ack = 1'($urandom_range(0, 1));
            cyc();
        end
        row_ack = 1'b0;
        cyc(); cyc();
        n_cmp++;
        if (m_dones - d0 != 3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL gaps_done_count: got %0d dones busy=%b expected 3 dones busy=0", m_dones - d0, busy);
        end
    endtask

    task automatic test_reset_mid_row();
        cmd_t c;
        logic [20:0] obs;
        int n_dn = 0, n_es = 0, d0;
        bit found = 1'b0;
        c.f = 3'($urandom_range(0, 7)); c.g = 1'($urandom_range(0, 1)); c.idx = 2;
        row_ack = 1'b1;
        pend.push_back(c);
        post(c.f, c.g, c.idx);
        for (int c2 = 0; c2 < 400 && !found; c2++) begin
            if (row_req === 1'b1 && row_addr === ADDR_W'(2 * IMG_H + 100)) found = 1'b1;
            else cyc();
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL midrow_reach: row 100 of image 2 not seen"); end
        rst_n = 1'b0;
        #1;
        obs = {rdy, busy, done, err_ovf, err_idx, eng_start, eng_func, eng_gray, row_req, row_addr};
        n_cmp++;
        if (obs !== 21'h100000) begin
            n_bad++;
            $display("FAIL midrow_reset_outputs: got %h expected %h", obs, 21'h100000);
        end
        pend.delete();
        cyc(); cyc();
        rst_n = 1'b1;
        for (int c2 = 0; c2 < 20; c2++) begin
            cyc();
            if (done === 1'b1) n_dn++;
            if (eng_start === 1'b1) n_es++;
        end
        n_cmp++;
        if (n_dn != 0 || n_es != 0) begin
            n_bad++;
            $display("FAIL midrow_no_done: got %0d dones %0d launches expected 0 and 0", n_dn, n_es);
        end
        c.idx = $urandom_range(0, 2);
        pend.push_back(c);
        d0 = m_dones;
        post(c.f, c.g, c.idx);
        found = 1'b0;
        for (int c2 = 0; c2 < 10 && !found; c2++) begin
            if (row_req === 1'b1) found = 1'b1;
            else cyc();
        end
        n_cmp++;
        if (!found || row_addr !== ADDR_W'(c.idx * IMG_H)) begin
            n_bad++;
            $display("FAIL midrow_restart_addr: got %0d (seen=%0d) expected %0d", row_addr, found, c.idx * IMG_H);
        end
        for (int c2 = 0; c2 < 400 && m_dones == d0; c2++) cyc();
        n_cmp++;
        if (m_dones - d0 != 1) begin
            n_bad++;
            $display("FAIL midrow_restart_done: got %0d dones expected 1", m_dones - d0);
        end
        cyc(); cyc();
    endtask

`ifdef COPROC_ABORT_EN
    task automatic test_abort();
        cmd_t c;
        int n_dn = 0, n_es = 0;
        bit found = 1'b0;
        c.f = 3'd5; c.g = 1'b0; c.idx = 1;
        row_ack = 1'b1;
        pend.push_back(c);
        post(c.f, c.g, c.idx);
        for (int c2 = 0; c2 < 200 && !found; c2++) begin
            if (row_req === 1'b1 && row_addr === ADDR_W'(IMG_H + 50)) found = 1'b1;
            else cyc();
        end
        row_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c.f = 3'($urandom_range(0, 7)); c.idx = $urandom_range(0, 2);
            pend.push_back(c);
            post(c.f, c.g, c.idx);
        end
        abort = 1'b1;
        post(3'd1, 1'b1, 0);  // discarded by abort
        abort = 1'b0;
        n_cmp++;
        if (!found || {row_req, rdy, busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL abort_state: got row_req,rdy,busy=%b (row50=%0d) expected 010", {row_req, rdy, busy}, found);
        end
        row_ack = 1'b1;
        for (int c2 = 0; c2 < 300; c2++) begin
            cyc();
            if (done === 1'b1) n_dn++;
            if (eng_start === 1'b1) n_es++;
        end
        row_ack = 1'b0;
        n_cmp++;
        if (n_dn != 0 || n_es != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d dones %0d launches expected 0 and 0", n_dn, n_es);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_err_idx();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_row();
`ifdef COPROC_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
